multi_port_sp_ram: RTL and testbench

- Single-port word memory shared by N_PORTS requesters (cores or fetch/data interfaces) through round-robin arbitration, at most one access per cycle.
- Speaks the core's req/gnt/rvalid memory protocol on every port, so the SoC can attach multiple cores, or a redundant core pair, to one memory.
- Optional LOCKSTEP mode serves ports 0/1 as a redundant pair with mismatch detection.
- Exposes shadowed flag/result words for the testbench.

---
 rtl/multi_port_sp_ram.sv | 221 ++++++++++++++++++++++
 tb/tb_multi_port_sp_ram.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_sp_ram.sv
// multi_port_sp_ram
// Single-port 32-bit word memory shared by N_PORTS requesters through a
// round-robin arbiter, one access per cycle, using the req/gnt/rvalid protocol.
// Optional LOCKSTEP mode merges ports 0/1 into one compared redundant pair.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   port_req_i/gnt_o      per-port request / same-cycle grant
//   port_addr_i/we_i/be_i/wdata_i   per-port access fields (port k at slice k)
//   port_rvalid_o/rdata_o/err_o     per-port response, one cycle after grant
//   mismatch_o            sticky lockstep mismatch flag
//   mem_flag_o/result_o   shadows of the words at FLAG_ADDR / RESULT_ADDR
module multi_port_sp_ram #(
  parameter int          N_PORTS     = 2,
  parameter int          DEPTH       = 4096,
  parameter logic [31:0] FLAG_ADDR   = 32'h0000_3FF8,
  parameter logic [31:0] RESULT_ADDR = 32'h0000_3FFC,
  parameter bit          LOCKSTEP    = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_PORTS-1:0]    port_req_i,
  output logic [N_PORTS-1:0]    port_gnt_o,
  output logic [N_PORTS-1:0]    port_rvalid_o,
  input  logic [32*N_PORTS-1:0] port_addr_i,
  input  logic [N_PORTS-1:0]    port_we_i,
  input  logic [4*N_PORTS-1:0]  port_be_i,
  input  logic [32*N_PORTS-1:0] port_wdata_i,
  output logic [32*N_PORTS-1:0] port_rdata_o,
  output logic [N_PORTS-1:0]    port_err_o,
  output logic                  mismatch_o,
  output logic [31:0]           mem_flag_o,
  output logic [31:0]           mem_result_o
);

  localparam int AW = $clog2(DEPTH);
  localparam bit LS = LOCKSTEP && (N_PORTS >= 2);
  // Arbitration slots: in lockstep the pair shares slot 0, port k>=2 is slot k-1.
  localparam int NS = LS ? N_PORTS - 1 : N_PORTS;
  localparam int PW = (NS > 1) ? $clog2(NS) : 1;
  // Partner port index, folded to 0 when there is no second port.
  localparam int P1 = (N_PORTS > 1) ? 1 : 0;
  localparam logic [AW-1:0] FLAG_IDX   = FLAG_ADDR[AW+1:2];
  localparam logic [AW-1:0] RESULT_IDX = RESULT_ADDR[AW+1:2];
  localparam bit FLAG_OK   = (FLAG_ADDR >> (AW + 2)) == 32'd0;
  localparam bit RESULT_OK = (RESULT_ADDR >> (AW + 2)) == 32'd0;

  function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    merge_be = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merge_be[8*b +: 8] = new_w[8*b +: 8];
    end
  endfunction

  logic [31:0] mem_q [DEPTH];

  logic [PW-1:0]          ptr_q, ptr_d;
  logic [3:0]             lone_cnt_q, lone_cnt_d;
  logic [N_PORTS-1:0]     rvalid_q, rvalid_d;
  logic [32*N_PORTS-1:0]  rdata_q, rdata_d;
  logic [N_PORTS-1:0]     err_q, err_d;
  logic                   mismatch_q, mismatch_d;
  logic [31:0]            flag_q, flag_d;
  logic [31:0]            result_q, result_d;

  logic [NS-1:0]      slot_req;
  logic               low_hit, high_hit, win_valid;
  int                 low_slot, high_slot, win_slot, sel_port;
  logic               pair_lone, lone_timeout, pair_differs;
  logic [N_PORTS-1:0] gnt;
  logic               acc_valid, acc_we, acc_oor, acc_write;
  logic [31:0]        acc_addr, acc_wdata, resp_rdata;
  logic [3:0]         acc_be;
  logic [AW-1:0]      acc_idx;

  // Round-robin search: the lowest requesting slot at or above the pointer
  // wins, otherwise wrap around to the lowest requesting slot overall.
  always_comb begin
    slot_req = '0;
    for (int s = 0; s < NS; s++) begin
      if (LS && s == 0) slot_req[s] = port_req_i[0] | port_req_i[P1];
      else              slot_req[s] = port_req_i[LS ? s + 1 : s];
    end
    low_hit   = 1'b0;
    low_slot  = 0;
    high_hit  = 1'b0;
    high_slot = 0;
    for (int s = NS - 1; s >= 0; s--) begin
      if (slot_req[s]) begin
        low_hit  = 1'b1;
        low_slot = s;
      end
      if (slot_req[s] && s >= int'(ptr_q)) begin
        high_hit  = 1'b1;
        high_slot = s;
      end
    end
    win_valid = low_hit;
    win_slot  = high_hit ? high_slot : low_slot;
  end

  // Grant generation. A winning pair slot with only one requester grants
  // nothing (the slot still holds the cycle) until its partner arrives or the
  // lone requester has waited 16 consecutive cycles.
  always_comb begin
    pair_lone    = LS && (port_req_i[0] ^ port_req_i[P1]);
    lone_timeout = pair_lone && (lone_cnt_q == 4'd15);
    gnt = '0;
    if (win_valid) begin
      for (int k = 0; k < N_PORTS; k++) begin
        if ((!LS || k >= 2) && win_slot == (LS ? k - 1 : k)) gnt[k] = 1'b1;
      end
      if (LS && win_slot == 0) begin
        if (port_req_i[0] && port_req_i[P1]) begin
          gnt[0]  = 1'b1;
          gnt[P1] = 1'b1;
        end else if (lone_timeout) begin
          gnt[0]  = port_req_i[0];
          gnt[P1] = port_req_i[P1];
        end
      end
    end
  end

  // Access fields come from the granted port; a pair uses port 0 unless port 1
  // was granted alone after the partner timeout.
  always_comb begin
    sel_port = LS ? win_slot + 1 : win_slot;
    if (LS && win_slot == 0) sel_port = gnt[0] ? 0 : P1;
    acc_valid = |gnt;
    acc_addr  = port_addr_i[31:0];
    acc_we    = port_we_i[0];
    acc_be    = port_be_i[3:0];
    acc_wdata = port_wdata_i[31:0];
    for (int k = 0; k < N_PORTS; k++) begin
      if (k == sel_port) begin
        acc_addr  = port_addr_i[32*k +: 32];
        acc_we    = port_we_i[k];
        acc_be    = port_be_i[4*k +: 4];
        acc_wdata = port_wdata_i[32*k +: 32];
      end
    end
    acc_oor   = (acc_addr >> (AW + 2)) != 32'd0;
    acc_idx   = acc_addr[AW+1:2];
    acc_write = acc_valid && acc_we && !acc_oor;
    pair_differs = (port_addr_i[31:0] != port_addr_i[32*P1 +: 32]) ||
                   (port_we_i[0] != port_we_i[P1]) ||
                   (port_be_i[3:0] != port_be_i[4*P1 +: 4]) ||
                   (port_we_i[0] && (port_wdata_i[31:0] != port_wdata_i[32*P1 +: 32]));
  end

  // Next-state of the response, pointer, lockstep and shadow registers.
  always_comb begin
    resp_rdata = (acc_we || acc_oor) ? 32'd0 : mem_q[acc_idx];
    ptr_d = ptr_q;
    if (acc_valid) ptr_d = PW'((win_slot + 1) % NS);
    rvalid_d = gnt;
    rdata_d  = rdata_q;
    err_d    = err_q;
    for (int k = 0; k < N_PORTS; k++) begin
      if (gnt[k]) begin
        rdata_d[32*k +: 32] = resp_rdata;
        err_d[k]            = acc_oor;
      end
    end
    lone_cnt_d = lone_cnt_q;
    if (!pair_lone || gnt[0] || gnt[P1]) lone_cnt_d = 4'd0;
    else if (lone_cnt_q != 4'd15)        lone_cnt_d = lone_cnt_q + 4'd1;
    mismatch_d = mismatch_q;
    if (lone_timeout) mismatch_d = 1'b1;
    if (LS && gnt[0] && gnt[P1] && pair_differs) mismatch_d = 1'b1;
    flag_d   = flag_q;
    result_d = result_q;
    if (acc_write && FLAG_OK && acc_idx == FLAG_IDX)
      flag_d = merge_be(flag_q, acc_wdata, acc_be);
    if (acc_write && RESULT_OK && acc_idx == RESULT_IDX)
      result_d = merge_be(result_q, acc_wdata, acc_be);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lone_cnt_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
      flag_q     <= '0;
      result_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lone_cnt_q <= lone_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
      flag_q     <= flag_d;
      result_q   <= result_d;
    end
  end

  // The array itself is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (acc_write) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign port_gnt_o    = gnt;
  assign port_rvalid_o = rvalid_q;
  assign port_rdata_o  = rdata_q;
  assign port_err_o    = err_q;
  assign mismatch_o    = mismatch_q;
  assign mem_flag_o    = flag_q;
  assign mem_result_o  = result_q;

endmodule

// File: tb/tb_multi_port_sp_ram.sv
// Testbench for multi_port_sp_ram: a 3-port instance driven by directed and
// random traffic against a word-level memory model, plus a 2-port lockstep
// instance exercised with directed pair accesses.
module tb_multi_port_sp_ram;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 3-port round-robin instance
  logic [2:0]  req3 = '0, gnt3, rvalid3, we3 = '0, err3;
  logic [95:0] addr3 = '0, wdata3 = '0, rdata3;
  logic [11:0] be3 = '0;
  logic        mism3;
  logic [31:0] flag3, result3;

  // 2-port lockstep instance
  logic [1:0]  reqL = '0, gntL, rvalidL, weL = '0, errL;
  logic [63:0] addrL = '0, wdataL = '0, rdataL;
  logic [7:0]  beL = '0;
  logic        mismL;
  logic [31:0] flagL, resultL;

  multi_port_sp_ram #(.N_PORTS(3), .DEPTH(4096), .LOCKSTEP(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst), .port_req_i(req3), .port_gnt_o(gnt3),
    .port_rvalid_o(rvalid3), .port_addr_i(addr3), .port_we_i(we3),
    .port_be_i(be3), .port_wdata_i(wdata3), .port_rdata_o(rdata3),
    .port_err_o(err3), .mismatch_o(mism3), .mem_flag_o(flag3),
    .mem_result_o(result3));

  multi_port_sp_ram #(.N_PORTS(2), .DEPTH(4096), .LOCKSTEP(1'b1)) u_ls (
    .clk_i(clk), .rst_i(rst), .port_req_i(reqL), .port_gnt_o(gntL),
    .port_rvalid_o(rvalidL), .port_addr_i(addrL), .port_we_i(weL),
    .port_be_i(beL), .port_wdata_i(wdataL), .port_rdata_o(rdataL),
    .port_err_o(errL), .mismatch_o(mismL), .mem_flag_o(flagL),
    .mem_result_o(resultL));

  int n_checks = 0;
  int n_fail   = 0;

  // Per-port request state held by the bench until granted
  bit          p_req   [3];
  logic [31:0] p_addr  [3];
  bit          p_we    [3];
  logic [3:0]  p_be    [3];
  logic [31:0] p_wdata [3];

  // Reference model: word array, validity, pointer, shadows, last responses
  logic [31:0] mdl_mem [4096];
  bit          mdl_vld [4096];
  int          mdl_ptr;
  logic [31:0] mdl_flag, mdl_result;
  logic [31:0] mdl_last [3];
  bit          mdl_err  [3];
  bit          mdl_known[3];
  logic [2:0]  last_gnt3;

  logic [31:0] pool [10];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // One cycle on the 3-port instance: drive held requests at the falling edge,
  // predict the grant, update the model, then check the response after the edge.
  task automatic applyStimulus(output int g);
    logic [2:0]  eg;
    logic [11:0] widx;
    bit          oor;
    int          k;
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      req3[p]             = p_req[p];
      addr3[32*p +: 32]   = p_addr[p];
      we3[p]              = p_we[p];
      be3[4*p +: 4]       = p_be[p];
      wdata3[32*p +: 32]  = p_wdata[p];
    end
    #1;
    g = -1;
    for (int i = 0; i < 3; i++) begin
      k = (mdl_ptr + i) % 3;
      if (p_req[k] && g < 0) g = k;
    end
    eg = '0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      mdl_ptr = (g + 1) % 3;
    end
    last_gnt3 = gnt3;
    checkOutput("gnt", 32'(gnt3), 32'(eg));
    if (g >= 0) begin
      oor  = p_addr[g] >= 32'h0000_4000;
      widx = p_addr[g][13:2];
      mdl_known[g] = 1'b1;
      mdl_err[g]   = oor;
      if (oor) begin
        mdl_last[g] = 32'd0;
      end else if (p_we[g]) begin
        mdl_last[g]   = 32'd0;
        mdl_mem[widx] = mergeBytes(mdl_mem[widx], p_wdata[g], p_be[g]);
        if (p_be[g] == 4'hF) mdl_vld[widx] = 1'b1;
        if (widx == 12'hFFE) mdl_flag   = mergeBytes(mdl_flag, p_wdata[g], p_be[g]);
        if (widx == 12'hFFF) mdl_result = mergeBytes(mdl_result, p_wdata[g], p_be[g]);
      end else begin
        mdl_last[g]  = mdl_mem[widx];
        mdl_known[g] = mdl_vld[widx];
      end
    end
    @(posedge clk);
    #1;
    checkOutput("rvalid", 32'(rvalid3), 32'(eg));
    for (int p = 0; p < 3; p++) begin
      if (mdl_known[p]) checkOutput($sformatf("rdata%0d", p), rdata3[32*p +: 32], mdl_last[p]);
      checkOutput($sformatf("err%0d", p), 32'(err3[p]), 32'(mdl_err[p]));
    end
    checkOutput("flag", flag3, mdl_flag);
    checkOutput("result", result3, mdl_result);
    checkOutput("mismatch3", 32'(mism3), 32'd0);
  endtask

  task automatic singleAccess(input int p, input logic [31:0] a, input bit we,
                              input logic [3:0] be, input logic [31:0] wd);
    int g;
    p_req[p] = 1'b1; p_addr[p] = a; p_we[p] = we; p_be[p] = be; p_wdata[p] = wd;
    applyStimulus(g);
    p_req[p] = 1'b0;
  endtask

  task automatic resetModel();
    mdl_ptr = 0; mdl_flag = '0; mdl_result = '0;
    for (int p = 0; p < 3; p++) begin
      p_req[p] = 1'b0; mdl_last[p] = '0; mdl_err[p] = 1'b0; mdl_known[p] = 1'b1;
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1; req3 = '0; reqL = '0;
    resetModel();
    #1;
    checkOutput("rst_rvalid3", 32'(rvalid3), 32'd0);
    checkOutput("rst_err3", 32'(err3), 32'd0);
    for (int p = 0; p < 3; p++) checkOutput($sformatf("rst_rdata%0d", p), rdata3[32*p +: 32], 32'd0);
    checkOutput("rst_flag3", flag3, 32'd0);
    checkOutput("rst_result3", result3, 32'd0);
    checkOutput("rst_mism3", 32'(mism3), 32'd0);
    checkOutput("rst_mismL", 32'(mismL), 32'd0);
    checkOutput("rst_rvalidL", 32'(rvalidL), 32'd0);
    checkOutput("rst_rdataL0", rdataL[31:0], 32'd0);
    checkOutput("rst_rdataL1", rdataL[63:32], 32'd0);
    checkOutput("rst_flagL", flagL, 32'd0);
    checkOutput("rst_resultL", resultL, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One identical-request (except wdata) pair access on the lockstep instance.
  task automatic lsAccess(input string tag, input logic [31:0] a, input bit we,
                          input logic [31:0] wd0, input logic [31:0] wd1,
                          input logic [31:0] exp_rd, input bit exp_mis);
    @(negedge clk);
    reqL = 2'b11; addrL = {a, a}; weL = {we, we}; beL = 8'hFF; wdataL = {wd1, wd0};
    #1;
    checkOutput({tag, "_gnt"}, 32'(gntL), 32'd3);
    @(posedge clk);
    #1;
    checkOutput({tag, "_rvalid"}, 32'(rvalidL), 32'd3);
    checkOutput({tag, "_rdata0"}, rdataL[31:0], exp_rd);
    checkOutput({tag, "_rdata1"}, rdataL[63:32], exp_rd);
    checkOutput({tag, "_err"}, 32'(errL), 32'd0);
    checkOutput({tag, "_mismatch"}, 32'(mismL), 32'(exp_mis));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g;
    int wait_cyc;
    pool = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114,
             32'h3FF8, 32'h3FFC, 32'h4000, 32'hFFFF_FFF0};
    for (int p = 0; p < 3; p++) begin
      p_addr[p] = '0; p_we[p] = 1'b0; p_be[p] = 4'hF; p_wdata[p] = '0;
    end
    resetModel();
    resetDut();

    // Basic write then read on port 0
    singleAccess(0, 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
    singleAccess(0, 32'h10, 1'b0, 4'hF, 32'h0);
    checkOutput("basic_read", rdata3[31:0], 32'hDEAD_BEEF);

    // Byte-enable merge
    singleAccess(1, 32'h20, 1'b1, 4'hF, 32'h1122_3344);
    singleAccess(1, 32'h20, 1'b1, 4'b0101, 32'hAABB_CCDD);
    singleAccess(1, 32'h22, 1'b0, 4'hF, 32'h0);
    checkOutput("be_merge", rdata3[63:32], 32'h11BB_33DD);

    // Contention from reset: strict rotation 0,1,2,0,1,2
    resetDut();
    for (int p = 0; p < 3; p++) begin
      p_req[p] = 1'b1; p_addr[p] = 32'h10; p_we[p] = 1'b0; p_be[p] = 4'hF;
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(g);
      checkOutput($sformatf("rr_gnt%0d", i), 32'(last_gnt3), 32'(1 << (i % 3)));
    end
    for (int p = 0; p < 3; p++) p_req[p] = 1'b0;

    // Out-of-range accesses
    singleAccess(2, 32'h4000, 1'b0, 4'hF, 32'h0);
    checkOutput("oor_err", 32'(err3[2]), 32'd1);
    checkOutput("oor_rdata", rdata3[95:64], 32'd0);
    singleAccess(0, 32'h4010, 1'b1, 4'hF, 32'h1234_5678);
    singleAccess(0, 32'h7FF8, 1'b1, 4'hF, 32'h0000_FFFF);
    singleAccess(0, 32'h10, 1'b0, 4'hF, 32'h0);
    checkOutput("oor_no_alias", rdata3[31:0], 32'hDEAD_BEEF);

    // Shadows
    singleAccess(0, 32'h3FF8, 1'b1, 4'hF, 32'h1);
    checkOutput("flag_set", flag3, 32'h1);
    singleAccess(1, 32'h3FFC, 1'b1, 4'hF, 32'h2A);
    checkOutput("result_set", result3, 32'h2A);
    resetDut();

    // Reset asserted while a response is pending drops it
    @(negedge clk);
    req3 = 3'b001; addr3[31:0] = 32'h10; we3 = '0;
    #1;
    checkOutput("pend_gnt", 32'(gnt3), 32'd1);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("pend_rvalid_rst", 32'(rvalid3), 32'd0);
    @(negedge clk);
    rst = 1'b0; req3 = '0;
    resetModel();
    @(posedge clk);
    #1;
    checkOutput("pend_rvalid_after", 32'(rvalid3), 32'd0);
    checkOutput("pend_rdata_after", rdata3[31:0], 32'd0);

    // Preload the in-range pool words, then random contention traffic
    for (int i = 0; i < 8; i++) singleAccess(i % 3, pool[i], 1'b1, 4'hF, $urandom);
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int p = 0; p < 3; p++) begin
        if (!p_req[p] && $urandom_range(0, 9) < 7) begin
          p_req[p]   = 1'b1;
          p_addr[p]  = pool[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
          p_we[p]    = 1'($urandom_range(0, 1));
          p_be[p]    = 4'($urandom_range(0, 15));
          p_wdata[p] = $urandom;
        end
      end
      applyStimulus(g);
      if (g >= 0) p_req[g] = 1'b0;
    end
    for (int p = 0; p < 3; p++) p_req[p] = 1'b0;

    // Lockstep pair
    resetDut();
    lsAccess("ls_wr", 32'h40, 1'b1, 32'd5, 32'd5, 32'd0, 1'b0);
    lsAccess("ls_rd", 32'h40, 1'b0, 32'd0, 32'd0, 32'd5, 1'b0);
    lsAccess("ls_wr_diff", 32'h44, 1'b1, 32'd5, 32'd7, 32'd0, 1'b1);
    lsAccess("ls_rd_diff", 32'h44, 1'b0, 32'd0, 32'd0, 32'd5, 1'b1);
    lsAccess("ls_sticky", 32'h40, 1'b0, 32'd0, 32'd0, 32'd5, 1'b1);
    resetDut();

    // Lone pair requester waits 16 cycles, then is granted alone with mismatch
    @(negedge clk);
    reqL = 2'b01; addrL = {32'h0, 32'h40}; weL = '0; beL = 8'hFF;
    wait_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (gntL != 2'b00) begin
        wait_cyc = c;
        break;
      end
      if (c == 15) checkOutput("lone_mis_early", 32'(mismL), 32'd0);
      @(negedge clk);
    end
    checkOutput("lone_wait", wait_cyc, 32'd16);
    checkOutput("lone_gnt", 32'(gntL), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("lone_mismatch", 32'(mismL), 32'd1);
    checkOutput("lone_rvalid", 32'(rvalidL), 32'd1);
    checkOutput("lone_rdata", rdataL[31:0], 32'd5);
    @(negedge clk);
    reqL = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
